sap_sequencer: RTL and testbench

//  Microcode sequencer for the 8-bit bus CPU: drives the 16-bit control word
//  for PC, MAR, RAM, IR, regA/regB, ALU and output register each clock.

---
 rtl/sap_sequencer_if.sv | 25 ++
 rtl/sap_sequencer.sv | 142 ++++++++++++++
 tb/tb_sap_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sap_sequencer_if.sv
// rtl/sap_sequencer_if.sv - control/status bundle between the SAP sequencer and its datapath.
interface sap_sequencer_if #(
  parameter int STEP_W = 3
);
  logic              step_en;
  logic [3:0]        opcode;
  logic              alu_carry;
  logic              alu_zero;
  logic              out_ready;
  logic [15:0]       ctrlwrd;
  logic [STEP_W-1:0] step;
  logic              halted;
  logic              flag_c;
  logic              flag_z;

  modport master (
    input  step_en, opcode, alu_carry, alu_zero, out_ready,
    output ctrlwrd, step, halted, flag_c, flag_z
  );

  modport slave (
    output step_en, opcode, alu_carry, alu_zero, out_ready,
    input  ctrlwrd, step, halted, flag_c, flag_z
  );
endinterface

// File: rtl/sap_sequencer.sv
// rtl/sap_sequencer.sv - variable-length microcode sequencer for the 8-bit bus CPU.
// Define COND_JUMP_EN to decode JC/JZ; otherwise those opcodes behave as NOP.
module sap_sequencer #(
  parameter bit OUT_HANDSHAKE = 1'b1,
  parameter int STEP_W        = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  sap_sequencer_if.master bus
);

`ifdef COND_JUMP_EN
  localparam bit CondJump = 1'b1;
`else
  localparam bit CondJump = 1'b0;
`endif

  localparam logic [15:0] C_FI = 16'h8000, C_HLT = 16'h4000, C_MI = 16'h2000, C_RI = 16'h1000;
  localparam logic [15:0] C_RO = 16'h0800, C_IO  = 16'h0400, C_II = 16'h0200, C_AI = 16'h0100;
  localparam logic [15:0] C_AO = 16'h0080, C_SO  = 16'h0040, C_SU = 16'h0020, C_BI = 16'h0010;
  localparam logic [15:0] C_OI = 16'h0008, C_CE  = 16'h0004, C_CO = 16'h0002, C_J  = 16'h0001;

  typedef enum logic [STEP_W-1:0] {
    T0 = STEP_W'(0),
    T1 = STEP_W'(1),
    T2 = STEP_W'(2),
    T3 = STEP_W'(3),
    T4 = STEP_W'(4)
  } step_e;

  step_e       step_q, step_d;
  logic        halted_q, halted_d;
  logic        flag_c_q, flag_c_d;
  logic        flag_z_q, flag_z_d;
  logic [15:0] word;
  logic [15:0] ctrl;
  logic        last;
  logic        stall;
  logic        nop_like;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      step_q   <= T0;
      halted_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  always_comb begin
    word     = '0;
    last     = 1'b0;
    stall    = 1'b0;
    nop_like = 1'b1;
    ctrl     = '0;
    step_d   = step_q;
    halted_d = halted_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;

    case (bus.opcode)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hE, 4'hF: nop_like = 1'b0;
      4'h7, 4'h8:                                     nop_like = !CondJump;
      default:                                        nop_like = 1'b1;
    endcase

    // Opcodes that change mid-instruction fall into the defaults and end the instruction.
    case (step_q)
      T0: word = C_MI | C_CO;
      T1: begin
        word = C_RO | C_II | C_CE;
        last = nop_like;
      end
      T2: begin
        last = 1'b1;
        case (bus.opcode)
          4'h1, 4'h2, 4'h3, 4'h5: begin
            word = C_MI | C_IO;
            last = 1'b0;
          end
          4'h4: word = C_IO | C_J;
          4'h6: word = C_IO | C_AI;
          4'h7: if (CondJump && flag_c_q) word = C_IO | C_J;
          4'h8: if (CondJump && flag_z_q) word = C_IO | C_J;
          4'hE: begin
            if (OUT_HANDSHAKE && !bus.out_ready) stall = 1'b1;
            else word = C_AO | C_OI;
          end
          4'hF: word = C_HLT;
          default: word = '0;
        endcase
      end
      T3: begin
        last = 1'b1;
        case (bus.opcode)
          4'h1: word = C_RO | C_AI;
          4'h2, 4'h3: begin
            word = C_RO | C_BI;
            last = 1'b0;
          end
          4'h5: word = C_AO | C_RI;
          default: word = '0;
        endcase
      end
      T4: begin
        last = 1'b1;
        case (bus.opcode)
          4'h2:    word = C_SO | C_AI | C_FI;
          4'h3:    word = C_SO | C_SU | C_AI | C_FI;
          default: word = '0;
        endcase
      end
      default: last = 1'b1;
    endcase

    if (rst_i || !bus.step_en) begin
      ctrl = '0;
    end else if (halted_q) begin
      ctrl = C_HLT;
    end else begin
      ctrl = word;
      if (!stall) step_d = last ? T0 : step_e'(step_q + STEP_W'(1));
      if (word[15]) begin
        flag_c_d = bus.alu_carry;
        flag_z_d = bus.alu_zero;
      end
      if (word[14]) halted_d = 1'b1;
    end
  end

  assign bus.ctrlwrd = ctrl;
  assign bus.step    = step_q;
  assign bus.halted  = halted_q;
  assign bus.flag_c  = flag_c_q;
  assign bus.flag_z  = flag_z_q;

endmodule

// File: tb/tb_sap_sequencer.sv
// tb/tb_sap_sequencer.sv - randomized bench for sap_sequencer against an instruction-table model.
module tb_sap_sequencer;
  localparam logic [15:0] FI = 16'h8000, HLT = 16'h4000, MI = 16'h2000, RI = 16'h1000;
  localparam logic [15:0] RO = 16'h0800, IO  = 16'h0400, II = 16'h0200, AI = 16'h0100;
  localparam logic [15:0] AO = 16'h0080, SO  = 16'h0040, SU = 16'h0020, BI = 16'h0010;
  localparam logic [15:0] OI = 16'h0008, CE  = 16'h0004, CO = 16'h0002, J  = 16'h0001;
`ifdef COND_JUMP_EN
  localparam bit CJ = 1'b1;
`else
  localparam bit CJ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sap_sequencer_if #(.STEP_W(3)) bus ();
  sap_sequencer #(.OUT_HANDSHAKE(1'b1), .STEP_W(3)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int m_idx  = 0;
  bit m_c    = 1'b0;
  bit m_z    = 1'b0;
  bit m_halt = 1'b0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int op_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h5:                   return 4;
      4'h2, 4'h3:                   return 5;
      4'h4, 4'h6, 4'hE, 4'hF:       return 3;
      4'h7, 4'h8:                   return CJ ? 3 : 2;
      default:                      return 2;
    endcase
  endfunction

  function automatic logic [15:0] op_word(input logic [3:0] op, input int i, input bit c, input bit z);
    if (i == 0) return MI | CO;
    if (i == 1) return RO | II | CE;
    case (op)
      4'h1: return (i == 2) ? (MI | IO) : (RO | AI);
      4'h2: return (i == 2) ? (MI | IO) : (i == 3) ? (RO | BI) : (SO | AI | FI);
      4'h3: return (i == 2) ? (MI | IO) : (i == 3) ? (RO | BI) : (SO | SU | AI | FI);
      4'h4: return IO | J;
      4'h5: return (i == 2) ? (MI | IO) : (AO | RI);
      4'h6: return IO | AI;
      4'h7: return c ? (IO | J) : 16'h0000;
      4'h8: return z ? (IO | J) : 16'h0000;
      4'hE: return AO | OI;
      4'hF: return HLT;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic bit m_stall();
    return (bus.opcode == 4'hE) && (m_idx == 2) && !bus.out_ready;
  endfunction

  function automatic logic [15:0] m_ctrl();
    if (rst || !bus.step_en) return 16'h0000;
    if (m_halt)              return HLT;
    if (m_stall())           return 16'h0000;
    return op_word(bus.opcode, m_idx, m_c, m_z);
  endfunction

  // Model advances on each rising edge; outputs are compared at the falling edge.
  initial begin
    logic [15:0] w;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_idx = 0; m_halt = 1'b0; m_c = 1'b0; m_z = 1'b0;
      end else if (bus.step_en && !m_halt && !m_stall()) begin
        w = op_word(bus.opcode, m_idx, m_c, m_z);
        if ((w & FI) != 0) begin
          m_c = bus.alu_carry;
          m_z = bus.alu_zero;
        end
        if ((w & HLT) != 0) m_halt = 1'b1;
        m_idx = (m_idx + 1 >= op_len(bus.opcode)) ? 0 : m_idx + 1;
      end
      @(negedge clk);
      if (chk_on) begin
        chk("ctrlwrd", bus.ctrlwrd, m_ctrl());
        chk("step", {13'd0, bus.step}, 16'(m_idx));
        chk("halted", {15'd0, bus.halted}, {15'd0, m_halt});
        chk("flag_c", {15'd0, bus.flag_c}, {15'd0, m_c});
        chk("flag_z", {15'd0, bus.flag_z}, {15'd0, m_z});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    logic [3:0] o;
    rst = 1'b1;
    bus.step_en = 1'b0; bus.opcode = 4'h0; bus.out_ready = 1'b1;
    bus.alu_carry = 1'b0; bus.alu_zero = 1'b0;
    ticks(2);
    chk_on = 1'b1;
    chk("rst_step", {13'd0, bus.step}, 16'h0000);
    chk("rst_halted", {15'd0, bus.halted}, 16'h0000);
    chk("rst_ctrl", bus.ctrlwrd, 16'h0000);
    rst = 1'b0; bus.step_en = 1'b1; bus.opcode = 4'h1;
    #1 chk("lda_t0", bus.ctrlwrd, 16'h2002);
    tick(); chk("lda_t1", bus.ctrlwrd, 16'h0A04); chk("lda_s1", {13'd0, bus.step}, 16'd1);
    tick(); chk("lda_t2", bus.ctrlwrd, 16'h2400); chk("lda_s2", {13'd0, bus.step}, 16'd2);
    tick(); chk("lda_t3", bus.ctrlwrd, 16'h0900); chk("lda_s3", {13'd0, bus.step}, 16'd3);
    tick(); chk("lda_end", {13'd0, bus.step}, 16'd0);

    bus.opcode = 4'h2; bus.alu_carry = 1'b1; bus.alu_zero = 1'b0;
    ticks(4); chk("add_t4", bus.ctrlwrd, 16'h8140);
    tick(); chk("add_c", {15'd0, bus.flag_c}, 16'd1); chk("add_z", {15'd0, bus.flag_z}, 16'd0);
    bus.opcode = 4'h3;
    ticks(4); chk("sub_t4", bus.ctrlwrd, 16'h8160);
    tick();

    bus.opcode = 4'h7;
    if (CJ) begin
      ticks(2); chk("jc_taken", bus.ctrlwrd, 16'h0401);
      tick(); chk("jc_end", {13'd0, bus.step}, 16'd0);
    end else begin
      ticks(2); chk("jc_nop_end", {13'd0, bus.step}, 16'd0);
    end

    bus.opcode = 4'hE; bus.out_ready = 1'b0;
    ticks(2);
    for (int k = 0; k < 3; k++) begin
      chk("out_stall_s", {13'd0, bus.step}, 16'd2);
      chk("out_stall_c", bus.ctrlwrd, 16'h0000);
      if (k < 2) tick();
    end
    bus.out_ready = 1'b1;
    #1 chk("out_go", bus.ctrlwrd, 16'h0088);
    tick(); chk("out_end", {13'd0, bus.step}, 16'd0);

    bus.opcode = 4'h2;
    ticks(2); bus.step_en = 1'b0;
    #1 chk("en_low_c", bus.ctrlwrd, 16'h0000);
    tick(); chk("en_low_s", {13'd0, bus.step}, 16'd2);
    bus.step_en = 1'b1;
    ticks(3);

    bus.opcode = 4'h1;
    ticks(3); rst = 1'b1;
    #1 chk("rst_t3_c", bus.ctrlwrd, 16'h0000);
    tick(); rst = 1'b0;
    #1 chk("rst_t0_c", bus.ctrlwrd, 16'h2002); chk("rst_t0_s", {13'd0, bus.step}, 16'd0);

    bus.opcode = 4'hF;
    ticks(2); chk("hlt_t2", bus.ctrlwrd, 16'h4000);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hlt_halted", {15'd0, bus.halted}, 16'd1);
      chk("hlt_ctrl", bus.ctrlwrd, 16'h4000);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    #1 chk("hlt_rst_h", {15'd0, bus.halted}, 16'd0);
    chk("hlt_rst_s", {13'd0, bus.step}, 16'd0);
    chk("hlt_rst_f", {14'd0, bus.flag_c, bus.flag_z}, 16'd0);

    for (int n = 0; n < 4000; n++) begin
      tick();
      if (m_idx == 0) begin
        o = 4'($urandom);
        if (o == 4'hF && ($urandom % 4) != 0) o = 4'($urandom_range(0, 14));
        bus.opcode = o;
      end
      bus.step_en   = ($urandom % 8) != 0;
      bus.out_ready = ($urandom % 2) != 0;
      bus.alu_carry = ($urandom % 2) != 0;
      bus.alu_zero  = ($urandom % 2) != 0;
      rst           = ($urandom % 150) == 0;
    end
    tick();
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
